hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the load enable of PC and IF/ID, the flush of IF/ID, the ID/EX bubble insert and the EX hold.
- Resolves load-use hazards, taken branches and jumps, and multi-cycle EX operations (mult/div) through a small state machine.
- Sits beside the hazard and forwarding logic and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_stall_ctrl_if.sv | 44 ++++
 rtl/hazard_stall_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline sequencing bus between the core datapath and hazard_stall_ctrl.
//   master: datapath side; drives ID/EX hazard info and reads stall controls.
//   slave : controller side; reads hazard info and drives stall controls.
// Signals:
//   id_rs, id_rt, id_uses_rt           - source operands of the ID instruction
//   ex_memread, ex_rt                  - load in EX and its destination
//   id_branch_taken, id_jump           - control-flow redirect resolved in ID
//   mc_start, mc_cycles                - multi-cycle EX op entry and its length
//   pc_ld, ifid_ld, ifid_flush         - fetch-side controls
//   idex_bubble, ex_hold               - execute-side controls
//   ctrl_state, stall_cnt              - debug visibility
interface hazard_stall_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rt;
  logic             id_branch_taken;
  logic             id_jump;
  logic             mc_start;
  logic [3:0]       mc_cycles;
  logic             pc_ld;
  logic             ifid_ld;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             ex_hold;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, id_branch_taken, id_jump,
           mc_start, mc_cycles,
    input  pc_ld, ifid_ld, ifid_flush, idex_bubble, ex_hold, ctrl_state, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, id_branch_taken, id_jump,
           mc_start, mc_cycles,
    output pc_ld, ifid_ld, ifid_flush, idex_bubble, ex_hold, ctrl_state, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Resolves load-use hazards, taken branches/jumps and multi-cycle EX operations,
// and counts cycles in which the PC was stalled (saturating).
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset; forces all controls low while asserted
//   io_hz - hazard_stall_ctrl_if slave modport (hazard inputs, stall controls, debug)
// Parameters:
//   REG_W      - register-specifier width
//   BR_PENALTY - cycles IF/ID is flushed after a taken branch or jump (1..7)
//   CNT_W      - stall-cycle counter width
module hazard_stall_ctrl #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned BR_PENALTY = 1,
  parameter int unsigned CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_stall_ctrl_if.slave  io_hz
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StBrFlush = 2'd1,
    StMcWait  = 2'd2
  } state_e;

  localparam logic [2:0] FlInit = 3'(BR_PENALTY - 1);

  state_e           r_state, w_state_d;
  logic [3:0]       r_mc_cnt, w_mc_cnt_d;
  logic [2:0]       r_fl_cnt, w_fl_cnt_d;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [REG_W-1:0] w_id_rs, w_id_rt, w_ex_rt;
  logic             w_lu, w_mc_go, w_redirect;
  logic             w_pc_ld, w_ifid_ld, w_ifid_flush, w_idex_bubble, w_ex_hold;

  assign w_id_rs = io_hz.id_rs;
  assign w_id_rt = io_hz.id_rt;
  assign w_ex_rt = io_hz.ex_rt;

  // A load into $0 never creates a real dependency.
  assign w_lu = io_hz.ex_memread & (w_ex_rt != '0) &
                ((w_ex_rt == w_id_rs) | (io_hz.id_uses_rt & (w_ex_rt == w_id_rt)));
  assign w_mc_go    = io_hz.mc_start & (io_hz.mc_cycles != 4'd0);
  assign w_redirect = io_hz.id_branch_taken | io_hz.id_jump;

  always_comb begin
    w_state_d     = r_state;
    w_mc_cnt_d    = r_mc_cnt;
    w_fl_cnt_d    = r_fl_cnt;
    w_pc_ld       = 1'b0;
    w_ifid_ld     = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_ex_hold     = 1'b0;

    case (r_state)
      StRun: begin
        if (w_mc_go) begin
          // Branch in ID is simply held in IF/ID and re-evaluated once EX frees up.
          w_ex_hold = 1'b1;
          if (io_hz.mc_cycles > 4'd1) begin
            w_mc_cnt_d = io_hz.mc_cycles - 4'd1;
            w_state_d  = StMcWait;
          end
        end else if (w_lu) begin
          // Branch operands are not valid yet, so the redirect is not taken now.
          w_idex_bubble = 1'b1;
        end else if (w_redirect) begin
          w_pc_ld      = 1'b1;
          w_ifid_ld    = 1'b1;
          w_ifid_flush = 1'b1;
          if (BR_PENALTY > 1) begin
            w_fl_cnt_d = FlInit;
            w_state_d  = StBrFlush;
          end
        end else begin
          w_pc_ld   = 1'b1;
          w_ifid_ld = 1'b1;
        end
      end
      StMcWait: begin
        w_ex_hold  = 1'b1;
        w_mc_cnt_d = r_mc_cnt - 4'd1;
        if (r_mc_cnt <= 4'd1) w_state_d = StRun;
      end
      StBrFlush: begin
        // Everything fetched here is wrong-path, so redirects and hazards are ignored.
        w_pc_ld      = 1'b1;
        w_ifid_ld    = 1'b1;
        w_ifid_flush = 1'b1;
        w_fl_cnt_d   = r_fl_cnt - 3'd1;
        if (r_fl_cnt <= 3'd1) w_state_d = StRun;
      end
      default: w_state_d = StRun;
    endcase

    if (!rst_n) begin
      w_pc_ld       = 1'b0;
      w_ifid_ld     = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      w_ex_hold     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StRun;
      r_mc_cnt <= 4'd0;
      r_fl_cnt <= 3'd0;
    end else begin
      r_state  <= w_state_d;
      r_mc_cnt <= w_mc_cnt_d;
      r_fl_cnt <= w_fl_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_ld && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign io_hz.pc_ld       = w_pc_ld;
  assign io_hz.ifid_ld     = w_ifid_ld;
  assign io_hz.ifid_flush  = w_ifid_flush;
  assign io_hz.idex_bubble = w_idex_bubble;
  assign io_hz.ex_hold     = w_ex_hold;
  assign io_hz.ctrl_state  = rst_n ? r_state : StRun;
  assign io_hz.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three instances (BR_PENALTY=1, BR_PENALTY=3,
// CNT_W=4) share one stimulus set.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mr, uses_rt, br, jmp, mcs;
  logic [4:0] ex_rt, rs, rt;
  logic [3:0] mcc;
  int total = 0;
  int bad = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) hz_a ();
  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) hz_b ();
  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(4))  hz_c ();

  assign hz_a.id_rs = rs;  assign hz_b.id_rs = rs;  assign hz_c.id_rs = rs;
  assign hz_a.id_rt = rt;  assign hz_b.id_rt = rt;  assign hz_c.id_rt = rt;
  assign hz_a.id_uses_rt = uses_rt;  assign hz_b.id_uses_rt = uses_rt;
  assign hz_c.id_uses_rt = uses_rt;
  assign hz_a.ex_memread = mr;  assign hz_b.ex_memread = mr;  assign hz_c.ex_memread = mr;
  assign hz_a.ex_rt = ex_rt;  assign hz_b.ex_rt = ex_rt;  assign hz_c.ex_rt = ex_rt;
  assign hz_a.id_branch_taken = br;  assign hz_b.id_branch_taken = br;
  assign hz_c.id_branch_taken = br;
  assign hz_a.id_jump = jmp;  assign hz_b.id_jump = jmp;  assign hz_c.id_jump = jmp;
  assign hz_a.mc_start = mcs;  assign hz_b.mc_start = mcs;  assign hz_c.mc_start = mcs;
  assign hz_a.mc_cycles = mcc;  assign hz_b.mc_cycles = mcc;  assign hz_c.mc_cycles = mcc;

  hazard_stall_ctrl #(.REG_W(5), .BR_PENALTY(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .io_hz(hz_a.slave));
  hazard_stall_ctrl #(.REG_W(5), .BR_PENALTY(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .io_hz(hz_b.slave));
  hazard_stall_ctrl #(.REG_W(5), .BR_PENALTY(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .io_hz(hz_c.slave));

  // EX holds the branch or a bubble, so no multi-cycle op can start during a flush.
  always @(posedge clk) begin
    if (rst_n && hz_b.ctrl_state == 2'd1)
      assert (!mcs) else $error("FAIL mc_start_in_br_flush act=1 req=0");
  end

  typedef struct {
    string      nm;
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       jmp;
    logic       mcs;
    logic [3:0] mcc;
    logic [4:0] exp; // {pc_ld, ifid_ld, ifid_flush, idex_bubble, ex_hold}
  } vec_t;

  vec_t vecs [12];

  function automatic logic [4:0] oa();
    return {hz_a.pc_ld, hz_a.ifid_ld, hz_a.ifid_flush, hz_a.idex_bubble, hz_a.ex_hold};
  endfunction
  function automatic logic [4:0] ob();
    return {hz_b.pc_ld, hz_b.ifid_ld, hz_b.ifid_flush, hz_b.idex_bubble, hz_b.ex_hold};
  endfunction
  function automatic logic [4:0] oc();
    return {hz_c.pc_ld, hz_c.ifid_ld, hz_c.ifid_flush, hz_c.idex_bubble, hz_c.ex_hold};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic idle();
    mr = 1'b0; uses_rt = 1'b0; br = 1'b0; jmp = 1'b0; mcs = 1'b0;
    ex_rt = 5'd0; rs = 5'd0; rt = 5'd0; mcc = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_lu();
    mr = 1'b1; ex_rt = 5'd8; rs = 5'd8;
  endtask

  initial begin
    idle();
    vecs[0]  = '{"idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000};
    vecs[1]  = '{"lu_rs",    1, 8, 8, 0, 0, 0, 0, 0, 0, 5'b00010};
    vecs[2]  = '{"lu_r0",    1, 0, 0, 0, 1, 0, 0, 0, 0, 5'b11000};
    vecs[3]  = '{"lu_rt",    1, 9, 3, 9, 1, 0, 0, 0, 0, 5'b00010};
    vecs[4]  = '{"rt_nouse", 1, 9, 3, 9, 0, 0, 0, 0, 0, 5'b11000};
    vecs[5]  = '{"no_load",  0, 8, 8, 8, 1, 0, 0, 0, 0, 5'b11000};
    vecs[6]  = '{"lu_br",    1, 8, 8, 0, 0, 1, 0, 0, 0, 5'b00010};
    vecs[7]  = '{"mc1",      0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00001};
    vecs[8]  = '{"mc0",      0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11000};
    vecs[9]  = '{"mc1_all",  1, 8, 8, 0, 0, 1, 0, 1, 1, 5'b00001};
    vecs[10] = '{"br",       0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11100};
    vecs[11] = '{"jmp",      0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11100};

    // Reset state, held low with idle inputs.
    #3;
    chk("rst_outs_a", oa(), 5'b0);
    chk("rst_outs_b", ob(), 5'b0);
    chk("rst_outs_c", oc(), 5'b0);
    chk("rst_state_a", hz_a.ctrl_state, 2'd0);
    chk("rst_cnt_a", hz_a.stall_cnt, 0);
    tick();
    rst_n = 1'b1;

    // Single-cycle vectors on the BR_PENALTY=1 instance; every one stays in RUN.
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      mr = vecs[i].mr; ex_rt = vecs[i].ex_rt; rs = vecs[i].rs; rt = vecs[i].rt;
      uses_rt = vecs[i].uses_rt; br = vecs[i].br; jmp = vecs[i].jmp;
      mcs = vecs[i].mcs; mcc = vecs[i].mcc;
      #2;
      chk(vecs[i].nm, oa(), vecs[i].exp);
      chk({vecs[i].nm, "_state"}, hz_a.ctrl_state, 2'd0);
      if (!vecs[i].exp[4]) exp_cnt++;
      tick();
      chk({vecs[i].nm, "_cnt"}, hz_a.stall_cnt, exp_cnt);
    end

    // Load-use: one stall, then release; counter 0 -> 1.
    do_reset();
    set_lu();
    #2;
    chk("lu_stall", oa(), 5'b00010);
    chk("lu_cnt0", hz_a.stall_cnt, 0);
    tick();
    mr = 1'b0;
    #2;
    chk("lu_release", oa(), 5'b11000);
    chk("lu_cnt1", hz_a.stall_cnt, 1);

    // Branch, penalty 1 (a) and 3 (b); second pulse inside b's window is ignored.
    do_reset();
    br = 1'b1;
    #2;
    chk("br1_a", oa(), 5'b11100);
    chk("br1_a_state", hz_a.ctrl_state, 2'd0);
    chk("br1_b", ob(), 5'b11100);
    chk("br1_b_state", hz_b.ctrl_state, 2'd0);
    tick();
    br = 1'b1;
    #2;
    chk("br2_b", ob(), 5'b11100);
    chk("br2_b_state", hz_b.ctrl_state, 2'd1);
    tick();
    br = 1'b0;
    #2;
    chk("br3_b", ob(), 5'b11100);
    chk("br3_b_state", hz_b.ctrl_state, 2'd1);
    chk("br3_a", oa(), 5'b11000);
    tick();
    #2;
    chk("br4_b", ob(), 5'b11000);
    chk("br4_b_state", hz_b.ctrl_state, 2'd0);
    tick();
    #2;
    chk("br5_b", ob(), 5'b11000);

    // Multi-cycle op of 4 cycles.
    do_reset();
    mcs = 1'b1; mcc = 4'd4;
    #2;
    chk("mc4_c1", oa(), 5'b00001);
    chk("mc4_c1_state", hz_a.ctrl_state, 2'd0);
    tick();
    mcs = 1'b0; mcc = 4'd0;
    for (int k = 2; k <= 4; k++) begin
      #2;
      chk("mc4_wait", oa(), 5'b00001);
      chk("mc4_wait_state", hz_a.ctrl_state, 2'd2);
      tick();
    end
    #2;
    chk("mc4_done", oa(), 5'b11000);
    chk("mc4_done_state", hz_a.ctrl_state, 2'd0);
    chk("mc4_cnt", hz_a.stall_cnt, 4);

    // Priority: mc_go beats load-use and branch; branch acts once EX frees up.
    do_reset();
    mcs = 1'b1; mcc = 4'd2; set_lu(); br = 1'b1;
    #2;
    chk("prio_c1", oa(), 5'b00001);
    tick();
    #2;
    chk("prio_c2", oa(), 5'b00001);
    chk("prio_c2_state", hz_a.ctrl_state, 2'd2);
    tick();
    mcs = 1'b0; mr = 1'b0;
    #2;
    chk("prio_br", oa(), 5'b11100);
    chk("prio_br_state", hz_a.ctrl_state, 2'd0);
    tick();
    idle();

    // Asynchronous reset in the second MC_WAIT cycle.
    do_reset();
    mcs = 1'b1; mcc = 4'd8;
    tick();
    mcs = 1'b0; mcc = 4'd0;
    tick();
    #2;
    chk("rmid_state_pre", hz_a.ctrl_state, 2'd2);
    chk("rmid_cnt_pre", hz_a.stall_cnt, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rmid_outs", oa(), 5'b0);
    chk("rmid_state", hz_a.ctrl_state, 2'd0);
    chk("rmid_cnt", hz_a.stall_cnt, 0);
    tick();
    #2;
    rst_n = 1'b1;
    #1;
    chk("rmid_rel_outs", oa(), 5'b11000);
    chk("rmid_rel_cnt", hz_a.stall_cnt, 0);
    tick();
    chk("rmid_run_state", hz_a.ctrl_state, 2'd0);
    chk("rmid_run_cnt", hz_a.stall_cnt, 0);

    // Saturation of the 4-bit counter under a held load-use.
    do_reset();
    set_lu();
    for (int n = 1; n <= 20; n++) begin
      tick();
      chk("sat_cnt", hz_c.stall_cnt, (n < 15) ? n : 15);
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
